// File: rtl/emergency_preempt_arbiter_pkg.sv
// Shared definitions for the emergency preemption arbiter: direction codes,
// arbiter state encoding, default timing constants and round-robin helpers.
package emergency_preempt_arbiter_pkg;

   localparam logic [1:0] DIR_N = 2'd0;
   localparam logic [1:0] DIR_S = 2'd1;
   localparam logic [1:0] DIR_E = 2'd2;
   localparam logic [1:0] DIR_W = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_t;

   localparam int DEF_DEB_CYCLES = 3;
   localparam int DEF_MIN_HOLD   = 8;
   localparam int DEF_MAX_HOLD   = 60;
   localparam int DEF_GAP_CYCLES = 4;

   function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
      return 4'b0001 << dir;
   endfunction

   // First pending direction strictly after the last grant, wrapping W -> N.
   function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] last);
      logic [1:0] pick;
      logic [1:0] idx;
      logic       found;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (!found && pend[idx]) begin
            pick  = idx;
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/req_debounce.sv
// Single-request debouncer: the stable output follows the raw input only after
// DEB_CYCLES consecutive samples of the new value; rise flags that completing edge.
module req_debounce #(
   parameter int DEB_CYCLES = 3
)(
   input  logic clk,
   input  logic rst_an,
   input  logic raw,
   output logic stable,
   output logic rise
);

   logic [3:0] cnt;
   logic       differ;
   logic       done;

   assign differ = (raw != stable);
   assign done   = differ && (cnt == 4'(DEB_CYCLES - 1));
   assign rise   = done && raw;

   // Run-length counter of samples disagreeing with the stable value
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         cnt    <= 4'd0;
         stable <= 1'b0;
      end else if (done) begin
         cnt    <= 4'd0;
         stable <= raw;
      end else if (differ) begin
         cnt    <= cnt + 4'd1;
      end else begin
         cnt    <= 4'd0;
      end
   end

endmodule

// File: rtl/emergency_preempt_arbiter.sv
// Arbitrates four debounced ambulance requests into a single registered
// preemption line with minimum/maximum hold and an all-low gap between grants.
module emergency_preempt_arbiter
   import emergency_preempt_arbiter_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int MIN_HOLD   = DEF_MIN_HOLD,
   parameter int MAX_HOLD   = DEF_MAX_HOLD,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
)(
   input  logic       clk,
   input  logic       rst_an,
   input  logic       req_n,
   input  logic       req_s,
   input  logic       req_e,
   input  logic       req_w,
   input  logic       emergency_mode,
   output logic       amb_n,
   output logic       amb_s,
   output logic       amb_e,
   output logic       amb_w,
   output logic [1:0] grant_dir,
   output logic       busy,
   output logic [3:0] pending,
   output logic       timeout
);

   arb_state_t state, state_next;
   logic [7:0] hold_cnt, hold_next, hold_inc;
   logic [7:0] gap_cnt, gap_next, gap_inc;
   logic [1:0] last_grant, last_next;
   logic [1:0] grant_next, pick;
   logic [3:0] amb, amb_next;
   logic [3:0] pend_next, pend_clr, pend_force, grant_mask;
   logic       timeout_next, busy_next;
   logic [3:0] raw_req, deb, deb_rise;

   assign raw_req = {req_w, req_e, req_s, req_n};
   assign {amb_w, amb_e, amb_s, amb_n} = amb;

   for (genvar g = 0; g < 4; g++) begin : g_deb
      req_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk    (clk),
         .rst_an (rst_an),
         .raw    (raw_req[g]),
         .stable (deb[g]),
         .rise   (deb_rise[g])
      );
   end

   assign hold_inc = hold_cnt + 8'd1;
   assign gap_inc  = (gap_cnt == 8'hFF) ? gap_cnt : gap_cnt + 8'd1;

   // Next-state and next-output decode; thresholds compare the count being loaded
   always_comb begin
      state_next   = state;
      hold_next    = hold_cnt;
      gap_next     = gap_cnt;
      last_next    = last_grant;
      grant_next   = grant_dir;
      amb_next     = 4'b0000;
      timeout_next = 1'b0;
      pend_clr     = 4'b0000;
      pend_force   = 4'b0000;
      pick         = rr_pick(pending, last_grant);
      case (state)
         ST_IDLE: begin
            if (pending != 4'b0000) begin
               state_next = ST_GRANT;
               grant_next = pick;
               last_next  = pick;
               hold_next  = 8'd0;
               amb_next   = dir_onehot(pick);
               pend_clr   = dir_onehot(pick);
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_GRANT: begin
            amb_next  = dir_onehot(grant_dir);
            hold_next = hold_inc;
            if (hold_inc >= 8'(MAX_HOLD)) begin
               state_next   = ST_RELEASE;
               amb_next     = 4'b0000;
               gap_next     = 8'd0;
               timeout_next = 1'b1;
               // Still requesting: rejoin the rotation behind the others
               pend_force   = deb[grant_dir] ? dir_onehot(grant_dir) : 4'b0000;
            end else if ((hold_inc >= 8'(MIN_HOLD)) && !deb[grant_dir]) begin
               state_next = ST_RELEASE;
               amb_next   = 4'b0000;
               gap_next   = 8'd0;
            end else begin
               state_next = ST_GRANT;
            end
         end
         ST_RELEASE: begin
            gap_next = gap_inc;
            if ((gap_inc >= 8'(GAP_CYCLES)) && !emergency_mode) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_RELEASE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            amb_next   = 4'b0000;
         end
      endcase
      grant_mask = (state == ST_GRANT) ? dir_onehot(grant_dir) : 4'b0000;
      pend_next  = ((pending | (deb_rise & ~grant_mask)) & ~pend_clr) | pend_force;
      busy_next  = (state_next != ST_IDLE);
   end

   // State, counters and all registered outputs
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         state      <= ST_IDLE;
         hold_cnt   <= 8'd0;
         gap_cnt    <= 8'd0;
         last_grant <= DIR_W;
         grant_dir  <= DIR_N;
         amb        <= 4'b0000;
         pending    <= 4'b0000;
         timeout    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_next;
         hold_cnt   <= hold_next;
         gap_cnt    <= gap_next;
         last_grant <= last_next;
         grant_dir  <= grant_next;
         amb        <= amb_next;
         pending    <= pend_next;
         timeout    <= timeout_next;
         busy       <= busy_next;
      end
   end

endmodule

// File: tb/tb_emergency_preempt_arbiter.sv
// Directed bench for emergency_preempt_arbiter; edge numbers count rising edges
// after reset release, with inputs set before the edge that samples them.
module tb_emergency_preempt_arbiter;

   logic       clk = 1'b0;
   logic       rst_an;
   logic       req_n, req_s, req_e, req_w;
   logic       emergency_mode;
   logic       amb_n, amb_s, amb_e, amb_w;
   logic [1:0] grant_dir;
   logic       busy;
   logic [3:0] pending;
   logic       timeout;
   logic [3:0] amb_vec;

   int checks = 0;
   int errors = 0;

   assign amb_vec = {amb_w, amb_e, amb_s, amb_n};

   emergency_preempt_arbiter dut (
      .clk            (clk),
      .rst_an         (rst_an),
      .req_n          (req_n),
      .req_s          (req_s),
      .req_e          (req_e),
      .req_w          (req_w),
      .emergency_mode (emergency_mode),
      .amb_n          (amb_n),
      .amb_s          (amb_s),
      .amb_e          (amb_e),
      .amb_w          (amb_w),
      .grant_dir      (grant_dir),
      .busy           (busy),
      .pending        (pending),
      .timeout        (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      req_n = 1'b0; req_s = 1'b0; req_e = 1'b0; req_w = 1'b0;
      emergency_mode = 1'b0;
      rst_an = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_an = 1'b1;
   endtask

   task automatic test_reset;
      req_n = 1'b1; req_s = 1'b1; req_e = 1'b1; req_w = 1'b1;
      emergency_mode = 1'b0;
      rst_an = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (amb_vec !== 4'b0000) begin errors++; $display("FAIL reset_amb: got %b expected 0000", amb_vec); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++;
      if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
      checks++;
      if (timeout !== 1'b0 || grant_dir !== 2'd0) begin
         errors++; $display("FAIL reset_timeout_dir: got %b/%0d expected 0/0", timeout, grant_dir);
      end
      do_reset();
   endtask

   task automatic test_first_request;
      logic [3:0] exp_p, exp_a;
      do_reset();
      req_n = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick();
         exp_p = (e == 3) ? 4'b0001 : 4'b0000;
         exp_a = (e == 4) ? 4'b0001 : 4'b0000;
         checks++;
         if (pending !== exp_p) begin errors++; $display("FAIL first_pending e%0d: got %b expected %b", e, pending, exp_p); end
         checks++;
         if (amb_vec !== exp_a) begin errors++; $display("FAIL first_amb e%0d: got %b expected %b", e, amb_vec, exp_a); end
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b expected 1", busy); end
      checks++;
      if (grant_dir !== 2'd0) begin errors++; $display("FAIL first_dir: got %0d expected 0", grant_dir); end
   endtask

   task automatic test_short_pulse;
      do_reset();
      for (int e = 1; e <= 12; e++) begin
         req_n = (e <= 2);
         tick();
         checks++;
         if (pending !== 4'b0000 || amb_vec !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse e%0d: got pend %b amb %b busy %b expected 0000/0000/0", e, pending, amb_vec, busy);
         end
      end
   endtask

   task automatic test_min_hold;
      logic [3:0] exp_a;
      logic       exp_b;
      do_reset();
      for (int e = 1; e <= 20; e++) begin
         req_e = (e <= 5);
         tick();
         exp_a = (e >= 4 && e <= 11) ? 4'b0100 : 4'b0000;
         exp_b = (e >= 4 && e <= 15);
         checks++;
         if (amb_vec !== exp_a) begin errors++; $display("FAIL min_hold_amb e%0d: got %b expected %b", e, amb_vec, exp_a); end
         checks++;
         if (busy !== exp_b) begin errors++; $display("FAIL min_hold_busy e%0d: got %b expected %b", e, busy, exp_b); end
      end
   endtask

   task automatic test_timeout;
      logic [3:0] exp_a, exp_p;
      logic       exp_t;
      int         pulses;
      pulses = 0;
      do_reset();
      req_s = 1'b1;
      for (int e = 1; e <= 72; e++) begin
         tick();
         exp_a = ((e >= 4 && e <= 63) || e >= 69) ? 4'b0010 : 4'b0000;
         exp_t = (e == 64);
         exp_p = (e == 3 || (e >= 64 && e <= 68)) ? 4'b0010 : 4'b0000;
         if (timeout === 1'b1) pulses++;
         checks++;
         if (amb_vec !== exp_a) begin errors++; $display("FAIL timeout_amb e%0d: got %b expected %b", e, amb_vec, exp_a); end
         checks++;
         if (timeout !== exp_t) begin errors++; $display("FAIL timeout_pulse e%0d: got %b expected %b", e, timeout, exp_t); end
         checks++;
         if (pending !== exp_p) begin errors++; $display("FAIL timeout_pending e%0d: got %b expected %b", e, pending, exp_p); end
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL timeout_count: got %0d expected 1", pulses); end
      req_s = 1'b0;
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_a, exp_p;
      do_reset();
      for (int e = 1; e <= 42; e++) begin
         req_n = (e <= 5); req_s = (e <= 5); req_w = (e <= 5);
         tick();
         if (e >= 4 && e <= 11)       exp_a = 4'b0001;
         else if (e >= 17 && e <= 24) exp_a = 4'b0010;
         else if (e >= 30 && e <= 37) exp_a = 4'b1000;
         else                         exp_a = 4'b0000;
         if (e < 3)       exp_p = 4'b0000;
         else if (e < 4)  exp_p = 4'b1011;
         else if (e < 17) exp_p = 4'b1010;
         else if (e < 30) exp_p = 4'b1000;
         else             exp_p = 4'b0000;
         checks++;
         if (amb_vec !== exp_a) begin errors++; $display("FAIL rr_amb e%0d: got %b expected %b", e, amb_vec, exp_a); end
         checks++;
         if (pending !== exp_p) begin errors++; $display("FAIL rr_pending e%0d: got %b expected %b", e, pending, exp_p); end
         if (e == 4 || e == 17 || e == 30) begin
            checks++;
            if (grant_dir !== ((e == 4) ? 2'd0 : (e == 17) ? 2'd1 : 2'd3)) begin
               errors++; $display("FAIL rr_dir e%0d: got %0d", e, grant_dir);
            end
         end
      end
   endtask

   task automatic test_emergency;
      logic [3:0] exp_a;
      do_reset();
      for (int e = 1; e <= 30; e++) begin
         req_n = (e <= 5); req_e = (e <= 5);
         emergency_mode = (e >= 12 && e <= 21);
         tick();
         if (e >= 4 && e <= 11)       exp_a = 4'b0001;
         else if (e >= 23 && e <= 30) exp_a = 4'b0100;
         else                         exp_a = 4'b0000;
         checks++;
         if (amb_vec !== exp_a) begin errors++; $display("FAIL emergency_amb e%0d: got %b expected %b", e, amb_vec, exp_a); end
      end
      emergency_mode = 1'b0;
   endtask

   task automatic test_reset_mid_grant;
      do_reset();
      for (int e = 1; e <= 6; e++) begin
         req_w = (e <= 5);
         tick();
      end
      checks++;
      if (amb_vec !== 4'b1000) begin errors++; $display("FAIL midrst_pre: got %b expected 1000", amb_vec); end
      #2;
      rst_an = 1'b0;
      #1;
      checks++;
      if (amb_vec !== 4'b0000 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_amb: got %b busy %b expected 0000 busy 0", amb_vec, busy);
      end
      checks++;
      if (timeout !== 1'b0 || pending !== 4'b0000 || grant_dir !== 2'd0) begin
         errors++; $display("FAIL midrst_state: got to %b pend %b dir %0d expected 0/0000/0", timeout, pending, grant_dir);
      end
      @(posedge clk);
      #1;
      rst_an = 1'b1;
      req_w = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         checks++;
         if (amb_vec !== 4'b0000 || timeout !== 1'b0) begin
            errors++; $display("FAIL midrst_after e%0d: got %b to %b expected 0000 to 0", e, amb_vec, timeout);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_request();
      test_short_pulse();
      test_min_hold();
      test_timeout();
      test_round_robin();
      test_emergency();
      test_reset_mid_grant();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/emergency_preempt_arbiter.md
EMERGENCY_PREEMPT_ARBITER -- requirements
Module: emergency_preempt_arbiter

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 3, meaning consecutive equal samples needed to change a debounced request (range 1..15).
REQ-002 SHALL have parameter MIN_HOLD, default 8, meaning the minimum cycles a grant is held (range 1..255).
REQ-003 SHALL have parameter MAX_HOLD, default 60, meaning the cycle count at which a grant is forcibly released (MIN_HOLD < MAX_HOLD <= 255).
REQ-004 SHALL have parameter GAP_CYCLES, default 4, meaning the minimum all-low cycles between grants (range 1..255).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_an, input, 1: reset is asynchronous and active-low.
REQ-007 SHALL have ports req_n, req_s, req_e, req_w, input, 1 each, raw ambulance detector requests, synchronous to clk.
REQ-008 SHALL have port emergency_mode, input, 1, the emergency acknowledge fed back from the intersection controller.
REQ-009 SHALL have ports amb_n, amb_s, amb_e, amb_w, output, 1 each, the preemption lines driven to the controller; at most one high.
REQ-010 SHALL have port grant_dir, output, 2, the granted direction (0=N,1=S,2=E,3=W); valid while busy=1.
REQ-011 SHALL have ports busy, output, 1 (state != IDLE); pending, output, 4 ({W,E,S,N}); timeout, output, 1 (one-cycle pulse).

Function
REQ-012 SHALL debounce each req_x: deb_x changes on the edge that completes DEB_CYCLES consecutive samples of the new value.
REQ-013 SHALL set pending[x] on the edge deb_x rises, and SHALL not set it while direction x holds the grant.
REQ-014 SHALL implement states IDLE, GRANT and RELEASE.
REQ-015 IDLE: if pending != 0, SHALL on the next edge enter GRANT, select direction d round-robin starting after last_grant, clear pending[d], and assert amb_d.
REQ-016 GRANT: SHALL hold amb_d and increment hold_cnt (8-bit, cleared on entry) every cycle.
REQ-017 GRANT: SHALL go to RELEASE when hold_cnt >= MIN_HOLD and deb_d = 0 (normal release).
REQ-018 GRANT: SHALL go to RELEASE when hold_cnt reaches MAX_HOLD regardless of deb_d, pulsing timeout for exactly that one cycle.
REQ-019 On a timeout release with deb_d still 1, SHALL re-set pending[d] on the RELEASE entry edge so d rejoins the rotation.
REQ-020 RELEASE: all amb_x SHALL be 0; gap_cnt SHALL count from 0, and the block SHALL go to IDLE once gap_cnt >= GAP_CYCLES and emergency_mode = 0.
REQ-021 RELEASE SHALL wait indefinitely while emergency_mode = 1, because the controller latches direction only on emergency entry.
REQ-022 Any deb_x drop before MIN_HOLD SHALL NOT shorten the grant.
REQ-023 Simultaneous pending requests SHALL be served one grant each in round-robin order; no direction is granted twice while another is pending.
REQ-024 All outputs SHALL be registered; first-request latency SHALL be DEB_CYCLES+1 edges from the first high sample to amb_x high.

Reset
REQ-025 rst_an low SHALL immediately force amb_x=0, grant_dir=0, busy=0, pending=0, timeout=0, state=IDLE, all counters 0, and every debouncer to 0.
REQ-026 Reset SHALL set last_grant to W, so N has first priority after reset.
REQ-027 Reset asserted mid-GRANT SHALL drop amb_x asynchronously, with no gap or timeout pulse.

Structure
REQ-028 A shared package SHALL hold the direction encodings DIR_N..DIR_W, the arbiter state encoding, and the default timing constants.
REQ-029 A sub-module req_debounce (one request, DEB_CYCLES parameter, counter plus stable output) SHALL be instantiated four times.

Verification
REQ-030 Bench SHALL check: req_n high from cycle 0 -> pending[0] at edge 3, amb_n=1 at edge 4, busy=1, grant_dir=0.
REQ-031 Bench SHALL check: req_n high for 2 cycles only -> pending and amb_n stay 0.
REQ-032 Bench SHALL check: req_e pulse of 5 cycles -> amb_e held exactly MIN_HOLD=8 cycles, then 0 for at least 4 cycles with emergency_mode=0.
REQ-033 Bench SHALL check: req_s held high -> amb_s high 60 cycles, timeout pulses once, RELEASE, then amb_s regranted.
REQ-034 Bench SHALL check: req_n, req_s, req_w asserted on the same cycle -> grants N, S, W in order, each separated by gap.
REQ-035 Bench SHALL check: emergency_mode held high 10 cycles after release -> amb lines stay 0 until it drops; rst_an low mid-grant -> amb 0 same cycle.
